// File: rtl/and16_bitserial.sv
// Bit-serial AND engine: one result bit per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   in_valid/in_ready   operand handshake (ready only when idle)
//   a, b                operands, sampled at accept
//   out_valid/out_ready result handshake
//   out                 result a&b, held until the next result
//   busy                high whenever the engine is not idle
module and16_bitserial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             last;

  // New bit enters at the top; after WIDTH shifts the
  // first computed bit has walked down to bit 0.
  assign res_nx   = {a_sh[0] & b_sh[0], res[WIDTH-1:1]};
  assign last     = (cnt == LAST);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = SHIFT;
      SHIFT:   if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          res  <= res_nx;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (last) begin
            out       <= res_nx;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and16_bitserial.sv
// Directed and streaming checks for the bit-serial AND engine.
// Expected values are hand-computed or a&b from the bench.
module tb_and16_bitserial;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  and16_bitserial #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] ta,
                      input logic [15:0] tb2);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = ta;
    b = tb2;
    while (!in_ready && n < 100) begin
      tick;
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit rdy_low);
    lat = 0;
    rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      tick;
      lat++;
    end
    if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input string tag,
                     input logic [15:0] ta,
                     input logic [15:0] tb2,
                     input logic [15:0] exp);
    int lat;
    bit rl;
    send(ta, tb2);
    wait_done(lat, rl);
    chk(tag, out, exp);
    tick;
  endtask

  initial begin
    int lat;
    bit rl;
    bit stable;
    int cyc;
    int done_n;
    int acc_n;
    logic [15:0] q[$];
    logic [15:0] e;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick;

    // 1: latency and in_ready during the shift
    send(16'hFFFF, 16'hA5A5);
    chk("t1_busy", busy, 1);
    wait_done(lat, rl);
    chk("t1_latency", lat, 16);
    chk("t1_out", out, 16'hA5A5);
    chk("t1_ready_low", rl, 1);
    tick;
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_ready", in_ready, 1);

    // 2: bit order
    run("t2_lsb", 16'h0001, 16'h8001, 16'h0001);
    run("t2_msb", 16'h8000, 16'h8000, 16'h8000);

    // 3: backpressure in DONE
    out_ready = 1'b0;
    send(16'h1234, 16'hFFFF);
    wait_done(lat, rl);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || out !== 16'h1234 || in_ready)
        stable = 1'b0;
      tick;
    end
    chk("t3_stable", stable, 1);
    chk("t3_out", out, 16'h1234);
    out_ready = 1'b1;
    tick;
    chk("t3_release_valid", out_valid, 0);
    chk("t3_release_ready", in_ready, 1);
    chk("t3_hold_out", out, 16'h1234);

    // 4: operand changes after accept are ignored
    send(16'hFFFF, 16'hFFFF);
    a = 16'h0000;
    b = 16'h0000;
    wait_done(lat, rl);
    chk("t4_out", out, 16'hFFFF);
    tick;

    // 5: reset in the middle of a shift
    send(16'hFFFF, 16'hFFFF);
    repeat (8) tick;
    reset = 1'b1;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_out", out, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    #2;
    reset = 1'b0;
    tick;
    run("t5_next", 16'h0F0F, 16'h00FF, 16'h000F);

    // 6: in_valid held high, random operands and backpressure
    cyc = 0;
    done_n = 0;
    acc_n = 0;
    while (done_n < 200 && cyc < 20000) begin
      in_valid = (acc_n < 200);
      a = 16'($urandom);
      b = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        q.push_back(a & b);
        acc_n++;
      end
      if (out_valid && out_ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("t6_stream", out, e);
        end else begin
          chk("t6_extra", 32'd1, 32'd0);
        end
        done_n++;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t6_count", done_n, 200);
    chk("t6_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
